// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding, BCD limits and preset conversion for the countdown timer
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;
  localparam logic [6:0] SEC_CLAMP = 7'd59;
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    logic [6:0] c;
    c = (v > SEC_CLAMP) ? SEC_CLAMP : v;
    return {4'(c / 7'd10), 4'(c % 7'd10)};
  endfunction
endpackage

// File: rtl/countdown_timer_digit.sv
// bcd_down_digit: one loadable BCD down-counting digit that wraps to MAX on borrow
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX9
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       dec,
  output logic [3:0] q,
  output logic       is_zero,
  output logic       borrow_out
);
  logic [3:0] r_q;
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) r_q <= '0;
    else if (ld) r_q <= ld_val;
    else if (dec) r_q <= is_zero ? MAX : r_q - 4'd1;
  assign q = r_q;
  assign is_zero = (r_q == 4'd0);
  assign borrow_out = dec & is_zero;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS.cc BCD down-counter with 100 Hz prescaler, pause/resume and expiry alarm
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int CW = 19
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       load,
  input  logic       start_stop,
  input  logic [6:0] set_min,
  input  logic [6:0] set_sec,
  output logic [3:0] cs0,
  output logic [3:0] cs1,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic       running,
  output logic       expired,
  output logic       alarm
);
  state_t r_state;
  logic [CW-1:0] r_ps;
  logic r_running, r_expired, r_alarm;
  logic [7:0] w_min, w_sec;
  logic [5:0][3:0] w_ld, w_q;
  logic [5:0] w_zs, w_bo;
  logic [6:0] w_dec;
  logic w_tick, w_zero, w_last;
  assign w_min = bcd_split(set_min);
  assign w_sec = bcd_split(set_sec);
  assign w_ld = {w_min, w_sec, 8'h00};
  assign w_tick = (r_state == RUN) && (r_ps == CW'(TICK_DIV - 1)) && !load && !start_stop;
  assign w_dec = {w_bo, w_tick};
  assign w_zero = &w_zs;
  assign w_last = (&w_zs[5:1]) && (w_q[0] == 4'd1);
  for (genvar g = 0; g < 6; g++) begin : g_dig
    bcd_down_digit #(.MAX((g == 3 || g == 5) ? BCD_MAX5 : BCD_MAX9)) u_dig (
      .clk(clk),
      .aclr(aclr),
      .ld(load),
      .ld_val(w_ld[g]),
      .dec(w_dec[g]),
      .q(w_q[g]),
      .is_zero(w_zs[g]),
      .borrow_out(w_bo[g])
    );
  end
  // a borrow out of m1 means the count was already empty: stop instead of wrapping on
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) begin
      r_state <= IDLE;
      r_ps <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= 1'b0;
      if (load) begin
        r_state <= IDLE;
        r_ps <= '0;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else
        case (r_state)
          IDLE:
            if (start_stop && !w_zero) begin
              r_state <= RUN;
              r_running <= 1'b1;
            end
          RUN:
            if (start_stop) begin
              r_state <= PAUSE;
              r_running <= 1'b0;
            end else begin
              r_ps <= w_tick ? '0 : r_ps + 1'b1;
              if (w_tick && (w_last || w_dec[6])) begin
                r_state <= DONE;
                r_running <= 1'b0;
                r_expired <= 1'b1;
                r_alarm <= 1'b1;
              end
            end
          PAUSE:
            if (start_stop) begin
              r_state <= RUN;
              r_running <= 1'b1;
            end
          default: ;
        endcase
    end
  assign {m1, m0, s1, s0, cs1, cs0} = {w_q[5], w_q[4], w_q[3], w_q[2], w_q[1], w_q[0]};
  assign running = r_running;
  assign expired = r_expired;
  assign alarm = r_alarm;
endmodule
